// File: rtl/vm1_dma_pkg.sv
// ----------------------------------------------------------------------------
// vm1_dma_pkg
// Shared types and constants for the vm1 Q-bus DMA arbiter.
//   arb_state_e    : arbiter FSM state (3-bit encoding)
//   DefaultTimeout : default watchdog limit in GRANT cycles
// ----------------------------------------------------------------------------
package vm1_dma_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StReq   = 3'd1,
        StAck   = 3'd2,
        StGrant = 3'd3,
        StRel   = 3'd4
    } arb_state_e;

    localparam int unsigned DefaultTimeout = 1023;

endpackage

// File: rtl/vm1_dma_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// vm1_rr_pick
// Combinational round-robin priority picker. Searches req upward starting at
// index rr, wrapping modulo NREQ, and returns the first set bit.
// Ports:
//   req    in  NREQ  request vector
//   rr     in  IDXW  starting index of the search (must be < NREQ)
//   winner out IDXW  index of the selected request (0 when none)
//   valid  out 1     at least one request is set
// ----------------------------------------------------------------------------
module vm1_rr_pick #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] rr,
    output logic [IDXW-1:0] winner,
    output logic            valid
);

    // (base + off) mod NREQ without a divider; base < NREQ and off < NREQ.
    function automatic logic [IDXW-1:0] wrap_idx(input logic [IDXW-1:0] base,
                                                 input int unsigned     off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return IDXW'(s);
    endfunction

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!valid && req[wrap_idx(rr, i)]) begin
                winner = wrap_idx(rr, i);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vm1_dma_arbiter.sv
// ----------------------------------------------------------------------------
// vm1_dma_arbiter
// Shares the vm1 Q-bus between NREQ on-board DMA masters. Runs the CPU
// bus-request handshake (pin_dmr / pin_dmgo / pin_sack) and grants the bus to
// one master at a time in round-robin order. All outputs are registered.
//
// Optional feature: define VM1_DMA_WATCHDOG_EN to bound each GRANT tenure to
// TIMEOUT cycles; an overrun forces release, sets the sticky arb_err flag and
// masks the offending master until it drops its request.
//
// Ports:
//   pin_clk   in   1     processor clock, rising edge
//   pin_dclo  in   1     asynchronous active-high reset
//   dma_req   in   NREQ  per-master request level, held for the whole tenure
//   dma_sync  in   NREQ  per-master own bus cycle in progress
//   dma_gnt   out  NREQ  one-hot grant
//   dma_owner out  IDXW  current or last owner index
//   pin_dmgo  in   1     DMA grant from the CPU
//   pin_sync  in   1     CPU bus-cycle strobe
//   pin_dmr   out  1     DMA request to the CPU
//   pin_sack  out  1     selection acknowledge to the CPU
//   arb_busy  out  1     arbiter not idle
//   arb_err   out  1     watchdog error (0 without the watchdog)
// ----------------------------------------------------------------------------
module vm1_dma_arbiter
    import vm1_dma_pkg::*;
#(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned IDXW    = (NREQ > 1) ? $clog2(NREQ) : 1,
    parameter int unsigned TIMEOUT = DefaultTimeout
) (
    input  logic            pin_clk,
    input  logic            pin_dclo,
    input  logic [NREQ-1:0] dma_req,
    input  logic [NREQ-1:0] dma_sync,
    output logic [NREQ-1:0] dma_gnt,
    output logic [IDXW-1:0] dma_owner,
    input  logic            pin_dmgo,
    input  logic            pin_sync,
    output logic            pin_dmr,
    output logic            pin_sack,
    output logic            arb_busy,
    output logic            arb_err
);

    arb_state_e      state_q, state_d;
    logic [IDXW-1:0] owner_q, owner_d;
    logic [IDXW-1:0] rr_q, rr_d;
    logic            dmr_q, dmr_d;
    logic            sack_q, sack_d;
    logic [NREQ-1:0] gnt_q, gnt_d;

    logic [NREQ-1:0] req_eff;
    logic [IDXW-1:0] pick_idx;
    logic            pick_valid;
    logic [IDXW-1:0] owner_inc;
    logic [NREQ-1:0] owner_oh;
    logic            release_ok;
    logic            wd_expire;

    assign owner_inc  = (owner_q == IDXW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
    assign owner_oh   = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;
    // The master must have finished its own open bus cycle before release.
    assign release_ok = !dma_req[owner_q] && !dma_sync[owner_q];

    vm1_rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .req    (req_eff),
        .rr     (rr_q),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

`ifdef VM1_DMA_WATCHDOG_EN
    localparam int unsigned WdW = $clog2(TIMEOUT + 1);

    logic [WdW-1:0]  wd_q, wd_d;
    logic            err_q, err_d;
    logic [NREQ-1:0] mask_q, mask_d;

    // Fires on the TIMEOUT-th GRANT cycle, so dma_gnt is high exactly TIMEOUT cycles.
    assign wd_expire = (state_q == StGrant) && (wd_q == WdW'(TIMEOUT - 1));
    assign req_eff   = dma_req & ~mask_q;
    assign arb_err   = err_q;

    always_comb begin
        wd_d   = wd_q;
        err_d  = err_q;
        // A masked master is unmasked once it lets go of its request.
        mask_d = mask_q & dma_req;
        if (state_q == StAck) begin
            wd_d = '0;
        end else if (state_q == StGrant) begin
            wd_d = wd_q + 1'b1;
        end
        // A clean release in the same cycle as expiry is not an error.
        if (wd_expire && !release_ok) begin
            err_d  = 1'b1;
            mask_d = mask_d | owner_oh;
        end
    end

    always_ff @(posedge pin_clk or posedge pin_dclo) begin
        if (pin_dclo) begin
            wd_q   <= '0;
            err_q  <= 1'b0;
            mask_q <= '0;
        end else begin
            wd_q   <= wd_d;
            err_q  <= err_d;
            mask_q <= mask_d;
        end
    end
`else
    localparam int unsigned unused_timeout = TIMEOUT;

    assign wd_expire = 1'b0;
    assign req_eff   = dma_req;
    assign arb_err   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        dmr_d   = dmr_q;
        sack_d  = sack_q;
        gnt_d   = gnt_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    owner_d = pick_idx;
                    dmr_d   = 1'b1;
                    state_d = StReq;
                end
            end
            StReq: begin
                // Abort wins over a simultaneous pin_dmgo; rr stays put.
                if (!dma_req[owner_q]) begin
                    dmr_d   = 1'b0;
                    state_d = StIdle;
                end else if (pin_dmgo && !pin_sync) begin
                    sack_d  = 1'b1;
                    dmr_d   = 1'b0;
                    state_d = StAck;
                end
            end
            StAck: begin
                gnt_d   = owner_oh;
                state_d = StGrant;
            end
            StGrant: begin
                if (release_ok || wd_expire) begin
                    gnt_d   = '0;
                    sack_d  = 1'b0;
                    rr_d    = owner_inc;
                    state_d = StRel;
                end
            end
            StRel: begin
                // Wait for the CPU to withdraw its grant before re-arbitrating.
                if (!pin_dmgo) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                dmr_d   = 1'b0;
                sack_d  = 1'b0;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge pin_clk or posedge pin_dclo) begin
        if (pin_dclo) begin
            state_q <= StIdle;
            owner_q <= '0;
            rr_q    <= '0;
            dmr_q   <= 1'b0;
            sack_q  <= 1'b0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            dmr_q   <= dmr_d;
            sack_q  <= sack_d;
            gnt_q   <= gnt_d;
        end
    end

    assign dma_gnt   = gnt_q;
    assign dma_owner = owner_q;
    assign pin_dmr   = dmr_q;
    assign pin_sack  = sack_q;
    assign arb_busy  = (state_q != StIdle);

endmodule
